mbox_wr_arbiter: RTL

- Shares the single byte-wide MAILBOX write port between NREQ word-wide requesters, e.g. the Wishbone MAILBOX_OBUF path and hardware status reporters.
- Arbitrates round-robin and serializes each granted 32-bit word least-significant byte first, honouring mbox_full_i.
- Locks the grant to one requester until that requester's packet ends, so packets never interleave.
- Sits in the wb_clk_i (clk_500) domain in front of the MAILBOX FIFO.

---
 rtl/mbox_wr_arbiter.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mbox_wr_arbiter.sv
// ---------------------------------------------------------------------------
// mbox_wr_arbiter
//
// Shares the byte-wide MAILBOX write port between NREQ word-wide requesters.
// Requesters are arbitrated round-robin. Each granted word is shifted out
// least-significant byte first, and writes stall while the MAILBOX is full.
// After a word that does not close its packet, the grant stays with the same
// requester (LOCK) until that requester sends its closing word. If the
// requester stays silent for LOCK_TMO cycles, the lock is abandoned.
//
// Handshake: a requester raises req_i[k] with dat/len/last and holds all of
// them stable until it sees the one-cycle ack_o[k] pulse. In the cycle after
// the ack it may present its next word or drop req_i[k]. A word is accepted
// at the clock edge that loads it. ack_o[k] is high during the first SHIFT
// cycle that follows that edge.
//
// Ports:
//   wb_clk_i     clock (clk_500 / Wishbone domain)
//   wb_rst_i     asynchronous active-high reset
//   req_i        per-requester word request
//   dat_i        requester k word at [k*WB_DW +: WB_DW]
//   len_i        requester k valid bytes minus one at [k*2 +: 2]
//   last_i       word closes the packet
//   ack_o        one-cycle registered pulse: word accepted
//   mbox_wr_o    MAILBOX write strobe
//   mbox_do_o    MAILBOX byte
//   mbox_full_i  MAILBOX full
//   gnt_o        one-hot current owner, 0 when idle
//   busy_o       arbiter not idle
//   tmo_o        one-cycle pulse: lock timeout abort
//   dbg_state_o  FSM state (0 IDLE, 1 SHIFT, 2 LOCK)
// ---------------------------------------------------------------------------
module mbox_wr_arbiter #(
    parameter int NREQ     = 3,
    parameter int WB_DW    = 32,
    parameter int WOU_DW   = 8,
    parameter int LOCK_TMO = 1024,
    parameter int TMO_W    = 11
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*WB_DW-1:0]   dat_i,
    input  logic [NREQ*2-1:0]       len_i,
    input  logic [NREQ-1:0]         last_i,
    output logic [NREQ-1:0]         ack_o,
    output logic                    mbox_wr_o,
    output logic [WOU_DW-1:0]       mbox_do_o,
    input  logic                    mbox_full_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic                    busy_o,
    output logic                    tmo_o,
    output logic [1:0]              dbg_state_o
);

    localparam int IW = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOCK  = 2'd2
    } state_t;

    state_t             r_state, w_state_n;
    logic [WB_DW-1:0]   r_buf, w_buf_n;
    logic [1:0]         r_cnt, w_cnt_n;
    logic [IW-1:0]      r_rr, w_rr_n;
    logic [IW-1:0]      r_own, w_own_n;
    logic               r_last, w_last_n;
    logic [TMO_W-1:0]   r_tmo_cnt, w_tmo_cnt_n;
    logic [NREQ-1:0]    r_gnt, w_gnt_n;
    logic [NREQ-1:0]    r_ack, w_ack_n;
    logic               r_tmo, w_tmo_n;

    // Round-robin scan: first set request at or above the rr pointer,
    // wrapping modulo NREQ (which need not be a power of two).
    logic [IW:0]        w_scan_sum;
    logic [IW-1:0]      w_scan_idx;
    logic [IW-1:0]      w_win;
    logic               w_any;

    always_comb begin
        w_any      = 1'b0;
        w_win      = '0;
        w_scan_sum = '0;
        w_scan_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_scan_sum = {1'b0, r_rr} + (IW+1)'(i);
            if (w_scan_sum >= (IW+1)'(NREQ)) begin
                w_scan_sum = w_scan_sum - (IW+1)'(NREQ);
            end
            w_scan_idx = w_scan_sum[IW-1:0];
            if (!w_any && req_i[w_scan_idx]) begin
                w_any = 1'b1;
                w_win = w_scan_idx;
            end
        end
    end

    // Word load source: the scan winner when idle, the owner when locked.
    logic [IW-1:0]      w_ld_idx;
    logic [WB_DW-1:0]   w_ld_dat;
    logic [1:0]         w_ld_len;
    logic               w_ld_last;
    logic [NREQ-1:0]    w_ld_onehot;
    logic [IW-1:0]      w_rr_after;

    always_comb begin
        w_ld_idx    = (r_state == S_LOCK) ? r_own : w_win;
        w_ld_dat    = dat_i[int'(w_ld_idx)*WB_DW +: WB_DW];
        w_ld_len    = len_i[int'(w_ld_idx)*2 +: 2];
        w_ld_last   = last_i[w_ld_idx];
        w_ld_onehot = NREQ'(1) << w_ld_idx;
        w_rr_after  = (r_own == IW'(NREQ-1)) ? '0 : r_own + 1'b1;
    end

    // State register (with datapath registers)
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_buf     <= '0;
            r_cnt     <= '0;
            r_rr      <= '0;
            r_own     <= '0;
            r_last    <= 1'b0;
            r_tmo_cnt <= '0;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_tmo     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_buf     <= w_buf_n;
            r_cnt     <= w_cnt_n;
            r_rr      <= w_rr_n;
            r_own     <= w_own_n;
            r_last    <= w_last_n;
            r_tmo_cnt <= w_tmo_cnt_n;
            r_gnt     <= w_gnt_n;
            r_ack     <= w_ack_n;
            r_tmo     <= w_tmo_n;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_n   = r_state;
        w_buf_n     = r_buf;
        w_cnt_n     = r_cnt;
        w_rr_n      = r_rr;
        w_own_n     = r_own;
        w_last_n    = r_last;
        w_tmo_cnt_n = r_tmo_cnt;
        w_gnt_n     = r_gnt;
        w_ack_n     = '0;
        w_tmo_n     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_n = S_SHIFT;
                    w_buf_n   = w_ld_dat;
                    w_cnt_n   = w_ld_len;
                    w_last_n  = w_ld_last;
                    w_own_n   = w_ld_idx;
                    w_gnt_n   = w_ld_onehot;
                    w_ack_n   = w_ld_onehot;
                end
            end

            S_SHIFT: begin
                // A full MAILBOX freezes buffer and count, so no byte is lost.
                if (!mbox_full_i) begin
                    w_buf_n = r_buf >> WOU_DW;
                    w_cnt_n = r_cnt - 2'd1;
                    if (r_cnt == 2'd0) begin
                        if (r_last) begin
                            w_state_n = S_IDLE;
                            w_rr_n    = w_rr_after;
                            w_gnt_n   = '0;
                        end else begin
                            w_state_n   = S_LOCK;
                            w_tmo_cnt_n = '0;
                        end
                    end
                end
            end

            S_LOCK: begin
                if (req_i[r_own]) begin
                    w_state_n = S_SHIFT;
                    w_buf_n   = w_ld_dat;
                    w_cnt_n   = w_ld_len;
                    w_last_n  = w_ld_last;
                    w_ack_n   = w_ld_onehot;
                end else if (r_tmo_cnt == TMO_W'(LOCK_TMO-1)) begin
                    w_state_n = S_IDLE;
                    w_rr_n    = w_rr_after;
                    w_gnt_n   = '0;
                    w_tmo_n   = 1'b1;
                end else begin
                    w_tmo_cnt_n = r_tmo_cnt + 1'b1;
                end
            end

            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        mbox_wr_o   = 1'b0;
        mbox_do_o   = '0;
        if (r_state == S_SHIFT) begin
            mbox_wr_o = ~mbox_full_i;
            mbox_do_o = r_buf[WOU_DW-1:0];
        end
        busy_o      = (r_state != S_IDLE);
        ack_o       = r_ack;
        gnt_o       = r_gnt;
        tmo_o       = r_tmo;
        dbg_state_o = r_state;
    end

endmodule
